// File: rtl/mul_result_acc.sv
// mul_result_acc: accumulates every LEN products from the shift-add multiplier
// into one sum, then buffers completed sums in a DEPTH-entry FIFO that is read
// through a valid/ready interface. The input side never stalls. If a sum
// completes while the FIFO is full and nothing is popped, that sum is dropped
// and drop_err is set.
//
// Optional feature: define MRA_DROP_CNT_EN to add drop_cnt[7:0], a saturating
// count of dropped sums.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clr             synchronous clear; it has priority over mul_done and pop
//   mul_result/done product input; one product per cycle with mul_done high
//   out_data/vld    head of the FIFO; out_vld means the FIFO is non-empty
//   out_rdy         consumer accept; a pop happens on out_vld & out_rdy
//   fifo_full       the FIFO holds DEPTH entries
//   drop_err        sticky flag: a completed sum was discarded
//   prod_cnt        number of products in the current partial sum
//   drop_cnt        (optional) saturating count of discarded sums
module mul_result_acc #(
  parameter int unsigned RW    = 8,
  parameter int unsigned LEN   = 4,
  parameter int unsigned AW    = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic [RW-1:0]         mul_result,
  input  logic                  mul_done,
  output logic [AW-1:0]         out_data,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic                  fifo_full,
  output logic                  drop_err,
  output logic [$clog2(LEN):0]  prod_cnt
`ifdef MRA_DROP_CNT_EN
  ,
  output logic [7:0]            drop_cnt
`endif
);

  localparam int unsigned CW = $clog2(LEN) + 1;
  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = IW + 1;

  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic          vld_q, vld_d;
  logic          full_q, full_d;
  logic          drop_q, drop_d;
  logic [AW-1:0] mem_q [DEPTH];
  logic [7:0]    dcnt_q, dcnt_d;

  logic          pop_c;
  logic          last_c;
  logic          push_c;
  logic [AW-1:0] sum_c;

  // Next-state logic: clear, then pop, then accumulate or complete a sum
  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    drop_d = drop_q;
    dcnt_d = dcnt_q;
    push_c = 1'b0;
    pop_c  = vld_q & out_rdy;
    last_c = (cnt_q == CW'(LEN - 1));
    sum_c  = acc_q + AW'(mul_result);

    if (clr) begin
      acc_d  = '0;
      cnt_d  = '0;
      wr_d   = '0;
      rd_d   = '0;
      drop_d = 1'b0;
      dcnt_d = '0;
    end else begin
      if (pop_c) begin
        rd_d = rd_q + PW'(1);
      end
      if (mul_done) begin
        if (last_c) begin
          acc_d = '0;
          cnt_d = '0;
          // A pop in the same cycle frees a slot, so a full FIFO can still accept the push
          if (!full_q || pop_c) begin
            push_c = 1'b1;
            wr_d   = wr_q + PW'(1);
          end else begin
            drop_d = 1'b1;
            if (dcnt_q != 8'hFF) begin
              dcnt_d = dcnt_q + 8'd1;
            end
          end
        end else begin
          acc_d = sum_c;
          cnt_d = cnt_q + CW'(1);
        end
      end
    end

    // The extra pointer MSB distinguishes full from empty
    vld_d  = (wr_d != rd_d);
    full_d = ((wr_d ^ rd_d) == PW'(DEPTH));
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      vld_q  <= 1'b0;
      full_q <= 1'b0;
      drop_q <= 1'b0;
      dcnt_q <= '0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      vld_q  <= vld_d;
      full_q <= full_d;
      drop_q <= drop_d;
      dcnt_q <= dcnt_d;
    end
  end

  // FIFO storage, reset so that out_data reads 0 after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_c) begin
      mem_q[wr_q[IW-1:0]] <= sum_c;
    end
  end

  assign out_data  = mem_q[rd_q[IW-1:0]];
  assign out_vld   = vld_q;
  assign fifo_full = full_q;
  assign drop_err  = drop_q;
  assign prod_cnt  = cnt_q;

`ifdef MRA_DROP_CNT_EN
  assign drop_cnt = dcnt_q;
`else
  logic unused_dcnt;
  assign unused_dcnt = ^dcnt_q;
`endif

endmodule

// File: tb/tb_mul_result_acc.sv
// Bench for mul_result_acc (LEN=4, DEPTH=4, RW=8, AW=10). It has three parts:
// a table of single-cycle vectors, hand-written corner sequences, and random
// traffic checked against a queue-based reference model.
module tb_mul_result_acc;

  localparam int LEN   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic [7:0] mul_result;
  logic       mul_done;
  logic [9:0] out_data;
  logic       out_vld;
  logic       out_rdy;
  logic       fifo_full;
  logic       drop_err;
  logic [2:0] prod_cnt;
`ifdef MRA_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  mul_result_acc #(.RW(8), .LEN(LEN), .AW(10), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .mul_result (mul_result),
    .mul_done   (mul_done),
    .out_data   (out_data),
    .out_vld    (out_vld),
    .out_rdy    (out_rdy),
    .fifo_full  (fifo_full),
    .drop_err   (drop_err),
    .prod_cnt   (prod_cnt)
`ifdef MRA_DROP_CNT_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    bit done;
    int res;
    bit rdy;
    bit vld;
    int data;
    int cnt;
  } vec_t;

  vec_t tbl[12];

  // Reference model state
  int q[$];
  int m_acc, m_cnt, m_dcnt;
  bit m_drop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string name, input bit vld, input int data, input int cnt,
                         input bit full, input bit drop);
    chk({name, ".vld"}, 32'(out_vld), 32'(vld));
    if (vld) chk({name, ".data"}, 32'(out_data), 32'(data));
    chk({name, ".cnt"}, 32'(prod_cnt), 32'(cnt));
    chk({name, ".full"}, 32'(fifo_full), 32'(full));
    chk({name, ".drop"}, 32'(drop_err), 32'(drop));
  endtask

  task automatic step(input bit d, input int r, input bit rdy, input bit c);
    mul_done   = d;
    mul_result = r[7:0];
    out_rdy    = rdy;
    clr        = c;
    @(posedge clk);
    #1;
  endtask

  task automatic model_step(input bit d, input int r, input bit rdy, input bit c);
    if (c) begin
      q.delete();
      m_acc = 0; m_cnt = 0; m_drop = 0; m_dcnt = 0;
      return;
    end
    if (rdy && q.size() > 0) void'(q.pop_front());
    if (d) begin
      if (m_cnt == LEN - 1) begin
        if (q.size() < DEPTH) q.push_back(m_acc + r);
        else begin
          m_drop = 1;
          if (m_dcnt < 255) m_dcnt++;
        end
        m_acc = 0;
        m_cnt = 0;
      end else begin
        m_acc += r;
        m_cnt++;
      end
    end
  endtask

  initial begin
    // Basic sum with gaps (3+5+7+9=24), then the maximum sum (4*255=1020)
    tbl[0]  = '{1'b1, 3,   1'b1, 1'b0, 0,    1};
    tbl[1]  = '{1'b0, 0,   1'b1, 1'b0, 0,    1};
    tbl[2]  = '{1'b1, 5,   1'b1, 1'b0, 0,    2};
    tbl[3]  = '{1'b0, 0,   1'b1, 1'b0, 0,    2};
    tbl[4]  = '{1'b1, 7,   1'b1, 1'b0, 0,    3};
    tbl[5]  = '{1'b1, 9,   1'b1, 1'b1, 24,   0};
    tbl[6]  = '{1'b0, 0,   1'b1, 1'b0, 0,    0};
    tbl[7]  = '{1'b1, 255, 1'b1, 1'b0, 0,    1};
    tbl[8]  = '{1'b1, 255, 1'b1, 1'b0, 0,    2};
    tbl[9]  = '{1'b1, 255, 1'b1, 1'b0, 0,    3};
    tbl[10] = '{1'b1, 255, 1'b1, 1'b1, 1020, 0};
    tbl[11] = '{1'b0, 0,   1'b1, 1'b0, 0,    0};

    rst_n = 1'b0; clr = 1'b0; mul_done = 1'b0; mul_result = '0; out_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 1'b0, 0, 0, 1'b0, 1'b0);
    chk("reset.data", 32'(out_data), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].done, tbl[i].res, tbl[i].rdy, 1'b0);
      chk_all($sformatf("tbl%0d", i), tbl[i].vld, tbl[i].data, tbl[i].cnt, 1'b0, 1'b0);
    end

    // Backpressure: five groups of 1s; the fifth is dropped
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 1, 1'b0, 1'b0);
      if (i == 15) chk("bp.notfull", 32'(fifo_full), 32'd0);
      if (i == 16) chk_all("bp.full", 1'b1, 4, 0, 1'b1, 1'b0);
      if (i == 20) chk_all("bp.drop", 1'b1, 4, 0, 1'b1, 1'b1);
    end
`ifdef MRA_DROP_CNT_EN
    chk("bp.dcnt", 32'(drop_cnt), 32'd1);
`endif
    for (int k = 0; k < 4; k++) begin
      chk(($sformatf("bp.drain%0d", k)), 32'(out_data), 32'd4);
      chk(($sformatf("bp.vld%0d", k)), 32'(out_vld), 32'd1);
      step(1'b0, 0, 1'b1, 1'b0);
    end
    chk_all("bp.empty", 1'b0, 0, 0, 1'b0, 1'b1);

    // clr mid-sum discards the partial sum and the product on the clr cycle
    step(1'b1, 10, 1'b1, 1'b0);
    step(1'b1, 20, 1'b1, 1'b0);
    step(1'b1, 30, 1'b1, 1'b1);
    chk_all("clr", 1'b0, 0, 0, 1'b0, 1'b0);
`ifdef MRA_DROP_CNT_EN
    chk("clr.dcnt", 32'(drop_cnt), 32'd0);
`endif
    for (int i = 0; i < 4; i++) step(1'b1, 1, 1'b1, 1'b0);
    chk_all("clr.sum", 1'b1, 4, 0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    chk_all("clr.after", 1'b0, 0, 0, 1'b0, 1'b0);

    // A full FIFO plus a simultaneous push and pop causes no drop
    for (int g = 0; g < 4; g++)
      for (int i = 0; i < 4; i++) step(1'b1, g + 1, 1'b0, 1'b0);
    chk_all("pp.full", 1'b1, 4, 0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 5, 1'b0, 1'b0);
    step(1'b1, 5, 1'b1, 1'b0);
    chk_all("pp.swap", 1'b1, 8, 0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("pp.order%0d", k), 32'(out_data), 32'(8 + 4 * k));
      step(1'b0, 0, 1'b1, 1'b0);
    end
    chk_all("pp.empty", 1'b0, 0, 0, 1'b0, 1'b0);

    // Asynchronous reset with two FIFO entries and three pending products
    for (int i = 0; i < 8; i++) step(1'b1, 2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 3, 1'b0, 1'b0);
    chk_all("ar.pre", 1'b1, 8, 3, 1'b0, 1'b0);
    mul_done = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_all("ar.rst", 1'b0, 0, 0, 1'b0, 1'b0);
    chk("ar.data", 32'(out_data), 32'd0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 6, 1'b1, 1'b0);
    chk_all("ar.sum", 1'b1, 24, 0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    chk_all("ar.after", 1'b0, 0, 0, 1'b0, 1'b0);

    // Random traffic against the reference model
    step(1'b0, 0, 1'b0, 1'b1);
    model_step(1'b0, 0, 1'b0, 1'b1);
    for (int n = 0; n < 3000; n++) begin
      int thr;
      bit d, rdy, c;
      int r;
      thr = (n / 500) % 3 == 0 ? 10 : ((n / 500) % 3 == 1 ? 50 : 90);
      d   = ($urandom % 2) == 1;
      r   = int'($urandom % 256);
      rdy = int'($urandom % 100) < thr;
      c   = ($urandom % 200) == 0;
      model_step(d, r, rdy, c);
      step(d, r, rdy, c);
      chk_all($sformatf("rnd%0d", n), q.size() > 0, (q.size() > 0) ? q[0] : 0, m_cnt,
              q.size() == DEPTH, m_drop);
`ifdef MRA_DROP_CNT_EN
      chk($sformatf("rnd%0d.dcnt", n), 32'(drop_cnt), 32'(m_dcnt));
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
